// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-RAM host-side master: command encodings, frame sizes, FSM states.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEL,
    ST_SHIFT,
    ST_WAIT,
    ST_READ,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// 10-bit frame register: parallel load, shifts out MSB first and shifts MISO in at the LSB.
module spi_shift_reg
  import spi_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  din,
  input  logic [FRAME_BITS-1:0] load_val,
  output logic                  msb,
  output logic [DATA_BITS-1:0]  rx_byte
);

  logic [FRAME_BITS-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_n)     q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[FRAME_BITS-2:0], din};
  end

  assign msb = q[FRAME_BITS-1];
  // byte as it will stand once din is shifted in, so the last sample lands in the same edge
  assign rx_byte = {q[DATA_BITS-2:0], din};

endmodule

// File: rtl/spi_ram_master.sv
// SPI master for the SPI-RAM slave: one {cmd,payload} frame per handshake, 8-bit readback on rd-data.
// state  | meaning
// IDLE   | SS_n high, ready for a command
// START  | SS_n low, MOSI 0
// SEL    | MOSI carries the write/read select bit
// SHIFT  | 10 frame bits out, MSB first
// WAIT   | read turnaround, RD_LATENCY cycles
// READ   | 8 MISO samples, MSB first
// DONE   | frame end cycle, ready again, rsp_valid on reads
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] WAIT_LOAD = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  state_t     state;
  logic [1:0] cmd_q;
  logic [3:0] cnt;
  logic       accept;
  logic       sr_shift;
  logic       sr_msb;
  logic [7:0] sr_rx;

  assign accept   = cmd_valid && cmd_ready;
  assign sr_shift = (state == ST_SEL) || (state == ST_SHIFT && cnt != 4'd0) || (state == ST_READ);

  spi_shift_reg u_sr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .shift    (sr_shift),
    .din      ((state == ST_READ) ? MISO : 1'b0),
    .load_val ({cmd, cmd_data}),
    .msb      (sr_msb),
    .rx_byte  (sr_rx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      busy      <= 1'b0;
      cmd_q     <= 2'b00;
      cnt       <= 4'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // DONE doubles as an idle cycle so frames can run with a single SS_n-high gap
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state     <= ST_START;
            SS_n      <= 1'b0;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cmd_q     <= cmd;
          end else begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        ST_START: begin
          state <= ST_SEL;
          MOSI  <= sr_msb;
        end
        ST_SEL: begin
          state <= ST_SHIFT;
          MOSI  <= sr_msb;
          cnt   <= 4'(FRAME_BITS - 1);
        end
        ST_SHIFT: begin
          if (cnt != 4'd0) begin
            MOSI <= sr_msb;
            cnt  <= cnt - 4'd1;
          end else begin
            MOSI <= 1'b0;
            if (cmd_q == CMD_RD_DATA) begin
              if (RD_LATENCY == 0) begin
                state <= ST_READ;
                cnt   <= 4'(DATA_BITS - 1);
              end else begin
                state <= ST_WAIT;
                cnt   <= WAIT_LOAD;
              end
            end else begin
              state     <= ST_DONE;
              SS_n      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_READ;
            cnt   <= 4'(DATA_BITS - 1);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_READ: begin
          if (cnt == 4'd0) begin
            state     <= ST_DONE;
            SS_n      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= sr_rx;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: two instances (RD_LATENCY 2 and 0) checked every cycle against a frame-timeline model.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [1:0] cmd       [2];
  logic [7:0] cmd_data  [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       busy      [2];
  logic       ss_n      [2];
  logic       mosi      [2];
  logic       miso      [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_ram_master #(.RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd(cmd[0]), .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));

  spi_ram_master #(.RD_LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd(cmd[1]), .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));

  // Model: t_m = cycles since accept (-1 = idle), slave memory answers reads
  int         t_m    [2];
  logic [1:0] fc     [2];
  logic [7:0] fd     [2];
  logic [7:0] rx_m   [2];
  logic [7:0] rsp_m  [2];
  logic [7:0] addr_m [2];
  bit         jr     [2];
  bit         mvalid = 0;
  logic [7:0] mem    [2][256];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int flen(input int i);
    return (fc[i] == 2'b11) ? 20 + lat(i) : 12;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : model_p
    int tl;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t_m[i]   = -1;
        jr[i]    = 1;
        rsp_m[i] = 8'h00;
      end else begin
        tl = flen(i);
        if (t_m[i] == -1 || t_m[i] == tl) begin
          if (!jr[i] && cmd_valid[i]) begin
            t_m[i] = 0;
            fc[i]  = cmd[i];
            fd[i]  = cmd_data[i];
            case (fc[i])
              2'b00:   addr_m[i] = fd[i];
              2'b01:   mem[i][addr_m[i]] = fd[i];
              2'b10:   addr_m[i] = fd[i];
              default: rx_m[i] = mem[i][addr_m[i]];
            endcase
          end else begin
            t_m[i] = -1;
          end
        end else begin
          t_m[i]++;
          if (t_m[i] == tl && fc[i] == 2'b11) rsp_m[i] = rx_m[i];
        end
        jr[i] = 0;
      end
    end
    mvalid = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (t_m[i] >= 0 && fc[i] == 2'b11 && t_m[i] >= 12 + lat(i) && t_m[i] <= 19 + lat(i))
        miso[i] = rx_m[i][7 - (t_m[i] - 12 - lat(i))];
      else
        miso[i] = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin : check_p
    logic       e_ss, e_mosi, e_busy, e_rdy, e_rv;
    logic [9:0] fr;
    int         t, tl;
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        t  = t_m[i];
        tl = flen(i);
        fr = {fc[i], fd[i]};
        if (t == -1) begin
          e_ss = 1; e_mosi = 0; e_busy = 0; e_rdy = !jr[i]; e_rv = 0;
        end else if (t < tl) begin
          e_ss = 0; e_busy = 1; e_rdy = 0; e_rv = 0;
          if (t == 1)                e_mosi = fc[i][1];
          else if (t >= 2 && t <= 11) e_mosi = fr[11 - t];
          else                       e_mosi = 0;
        end else begin
          e_ss = 1; e_mosi = 0; e_busy = 0; e_rdy = 1; e_rv = (fc[i] == 2'b11);
        end
        chk("ss_n",      i, 32'(ss_n[i]),      32'(e_ss));
        chk("mosi",      i, 32'(mosi[i]),      32'(e_mosi));
        chk("busy",      i, 32'(busy[i]),      32'(e_busy));
        chk("cmd_ready", i, 32'(cmd_ready[i]), 32'(e_rdy));
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rv));
        chk("rsp_data",  i, 32'(rsp_data[i]),  32'(rsp_m[i]));
      end
    end
  end

  logic       s_ss   [32];
  logic       s_mosi [32];
  logic       s_rv   [32];
  logic [7:0] s_rd   [32];

  task automatic issue(input int i, input logic [1:0] c, input logic [7:0] d);
    int k;
    k = 0;
    while (cmd_ready[i] !== 1'b1 && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    chk("issue_ready_wait", i, 32'(k < 64), 32'd1);
    cmd_valid[i] = 1'b1;
    cmd[i]       = c;
    cmd_data[i]  = d;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd[i]       = 2'($urandom);
    cmd_data[i]  = 8'($urandom);
  endtask

  task automatic cap(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_ss[k]   = ss_n[i];
      s_mosi[k] = mosi[i];
      s_rv[k]   = rsp_valid[i];
      s_rd[k]   = rsp_data[i];
    end
  endtask

  function automatic logic [31:0] vec_ss(input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = {v[30:0], s_ss[k]};
    return v;
  endfunction

  function automatic logic [31:0] vec_mosi(input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = {v[30:0], s_mosi[k]};
    return v;
  endfunction

  function automatic logic [31:0] vec_rv(input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = {v[30:0], s_rv[k]};
    return v;
  endfunction

  initial begin
    int ngaps, run;
    bit seen_low;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 0; cmd[i] = 0; cmd_data[i] = 0; miso[i] = 0;
      t_m[i] = -1; fc[i] = 0; fd[i] = 0; rx_m[i] = 0; rsp_m[i] = 0; addr_m[i] = 0; jr[i] = 1;
      for (int a = 0; a < 256; a++) mem[i][a] = 8'($urandom);
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_reset", 0, 32'(cmd_ready[0]), 32'd1);

    // wr-addr 0x3A waveform
    issue(0, 2'b00, 8'h3A);
    cap(0, 13);
    chk("t1_mosi_bits", 0, vec_mosi(12), 32'h03A);
    chk("t1_ss_n",      0, vec_ss(13),   32'h0001);
    chk("t1_no_rsp",    0, vec_rv(13),   32'h0);

    // rd-data with L=2 returning 0xA5
    mem[0][8'h3A] = 8'hA5;
    issue(0, 2'b11, 8'h00);
    cap(0, 23);
    chk("t2_rsp_valid_T22", 0, vec_rv(23), 32'h1);
    chk("t2_ss_n",          0, vec_ss(23), 32'h1);
    chk("t2_rsp_data",      0, 32'(s_rd[22]), 32'hA5);

    // write/readback loop through the slave
    issue(0, 2'b00, 8'h10);
    issue(0, 2'b01, 8'h5C);
    issue(0, 2'b10, 8'h10);
    issue(0, 2'b11, 8'hFF);
    cap(0, 23);
    chk("t3_rsp_valid", 0, 32'(s_rv[22]), 32'd1);
    chk("t3_loopback",  0, 32'(s_rd[22]), 32'h5C);

    // reset in T5 of a write
    issue(0, 2'b01, 8'h99);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ss_n_high",  0, 32'(ss_n[0]),      32'd1);
    chk("t4_busy_low",   0, 32'(busy[0]),      32'd0);
    chk("t4_no_rsp",     0, 32'(rsp_valid[0]), 32'd0);
    chk("t4_rsp_clear",  0, 32'(rsp_data[0]),  32'h00);
    @(negedge clk);
    chk("t4_ready_back", 0, 32'(cmd_ready[0]), 32'd1);

    // cmd_valid held: back-to-back frames
    cmd_valid[0] = 1'b1; cmd[0] = 2'b01; cmd_data[0] = 8'h77;
    ngaps = 0; run = 0; seen_low = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ss_n[0] == 1'b0) begin
        if (seen_low && run > 0) begin
          chk("t5_gap_len", 0, 32'(run), 32'd1);
          ngaps++;
        end
        run = 0;
        seen_low = 1;
      end else if (seen_low) begin
        run++;
      end
    end
    cmd_valid[0] = 1'b0;
    chk("t5_gap_count", 0, 32'(ngaps), 32'd3);
    repeat (20) @(negedge clk);

    // rd-data with L=0 returning 0xC3
    mem[1][addr_m[1]] = 8'hC3;
    issue(1, 2'b11, 8'h00);
    cap(1, 21);
    chk("t6_rsp_valid_T20", 1, vec_rv(21), 32'h1);
    chk("t6_ss_n",          1, vec_ss(21), 32'h1);
    chk("t6_rsp_data",      1, 32'(s_rd[20]), 32'hC3);

    // random traffic on both instances, with occasional resets
    for (int k = 0; k < 2500; k++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        cmd_valid[i] = ($urandom_range(0, 2) == 0);
        cmd[i]       = 2'($urandom);
        cmd_data[i]  = 8'($urandom_range(0, 7));
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) cmd_valid[i] = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
